conv_stream_host: RTL and testbench

Host-side stream endpoint for the `conv_<X>_<F>_<T>_<P>` accelerators. It holds an input vector in a local buffer and transmits it over the x valid/ready channel. It then receives the convolution results over the y valid/ready channel into a result buffer and reports completion and a cycle count. It sits between the system/bench load port and the accelerator's `x_*`/`y_*` ports.

---
 rtl/conv_stream_host_if.sv | 32 +++
 rtl/conv_stream_host.sv | 140 ++++++++++++++
 tb/tb_conv_stream_host.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_host_if.sv
// Stream channel between the host endpoint and a conv accelerator.
//   x_data/x_valid/x_ready : host -> accelerator input words
//   y_data/y_valid/y_ready : accelerator -> host result words
// master: host side (drives x, accepts y). slave: accelerator side.
interface conv_stream_host_if #(
   parameter int unsigned T = 16
) ();
   logic signed [T-1:0] x_data;
   logic                x_valid;
   logic                x_ready;
   logic signed [T-1:0] y_data;
   logic                y_valid;
   logic                y_ready;

   modport master (
      output x_data,
      output x_valid,
      input  x_ready,
      input  y_data,
      input  y_valid,
      output y_ready
   );

   modport slave (
      input  x_data,
      input  x_valid,
      output x_ready,
      output y_data,
      output y_valid,
      input  y_ready
   );
endinterface

// File: rtl/conv_stream_host.sv
// Host-side stream endpoint for the conv accelerators. Holds an x vector in a local buffer,
// streams it out over the x channel, collects y results into a result buffer and reports
// completion plus the number of cycles spent sending.
//   clk, reset          : clock, synchronous active-high reset
//   ld_wr_en/addr/data  : x buffer load port (ignored while a run is active)
//   start               : single-cycle run request (ignored while busy)
//   busy, done, cycles  : run status and SEND-cycle count (saturating)
//   strm                : x/y valid-ready channels (master side)
//   rd_addr, rd_data    : result buffer read port, 1-cycle latency
module conv_stream_host #(
   parameter int unsigned T      = 16,
   parameter int unsigned SIZE_X = 128,
   parameter int unsigned SIZE_Y = 121,
   parameter int unsigned CW     = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ld_wr_en,
   input  logic [$clog2(SIZE_X)-1:0]  ld_addr,
   input  logic signed [T-1:0]        ld_data,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [CW-1:0]              cycles,
   conv_stream_host_if.master         strm,
   input  logic [$clog2(SIZE_Y)-1:0]  rd_addr,
   output logic signed [T-1:0]        rd_data
);
   localparam int unsigned AX = $clog2(SIZE_X);
   localparam int unsigned AY = $clog2(SIZE_Y);
   localparam int unsigned CX = $clog2(SIZE_X + 1);
   localparam int unsigned CY = $clog2(SIZE_Y + 1);
   localparam logic [CX-1:0] XNum   = CX'(SIZE_X);
   localparam logic [CX-1:0] XNumM1 = CX'(SIZE_X - 1);
   localparam logic [CY-1:0] YNum   = CY'(SIZE_Y);
   localparam logic [CY-1:0] YNumM1 = CY'(SIZE_Y - 1);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   state_e              state_q;
   logic signed [T-1:0] x_mem [SIZE_X];
   logic signed [T-1:0] y_mem [SIZE_Y];
   logic [CX-1:0]       rd_ptr_q;   // next x buffer address to fetch
   logic [CX-1:0]       x_sent_q;
   logic [CY-1:0]       y_rcvd_q;
   logic signed [T-1:0] ram_q;      // prefetch entry (x buffer read register)
   logic                ram_vld_q;
   logic                x_xfer, y_xfer, x_load, ram_rd, x_fin, y_fin;

   assign busy         = (state_q == StSend);
   assign done         = (state_q == StDone);
   assign strm.y_ready = (state_q == StSend) && (y_rcvd_q < YNum);

   // Two entries (ram_q, x_data) give 1 word/cycle: the prefetch refills in the same cycle
   // the output register drains.
   always_comb begin
      x_xfer = strm.x_valid && strm.x_ready;
      y_xfer = strm.y_valid && strm.y_ready;
      x_load = ram_vld_q && (!strm.x_valid || x_xfer);
      ram_rd = (rd_ptr_q < XNum) && (!ram_vld_q || x_load);
      x_fin  = (x_sent_q == XNum) || (x_xfer && (x_sent_q == XNumM1));
      y_fin  = (y_rcvd_q == YNum) || (y_xfer && (y_rcvd_q == YNumM1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         rd_ptr_q     <= '0;
         x_sent_q     <= '0;
         y_rcvd_q     <= '0;
         ram_q        <= '0;
         ram_vld_q    <= 1'b0;
         strm.x_data  <= '0;
         strm.x_valid <= 1'b0;
         cycles       <= '0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  // Word 0 is fetched on the accepting edge so x_valid rises one edge later.
                  state_q      <= StSend;
                  ram_q        <= x_mem[0];
                  ram_vld_q    <= 1'b1;
                  rd_ptr_q     <= CX'(1);
                  x_sent_q     <= '0;
                  y_rcvd_q     <= '0;
                  cycles       <= '0;
                  strm.x_valid <= 1'b0;
               end
            end
            StSend: begin
               if (ram_rd) begin
                  ram_q    <= x_mem[rd_ptr_q[AX-1:0]];
                  rd_ptr_q <= rd_ptr_q + CX'(1);
               end
               ram_vld_q <= ram_rd || (ram_vld_q && !x_load);
               if (x_load) begin
                  strm.x_data <= ram_q;
               end
               strm.x_valid <= x_load || (strm.x_valid && !x_xfer);
               if (x_xfer) begin
                  x_sent_q <= x_sent_q + CX'(1);
               end
               if (y_xfer) begin
                  y_rcvd_q <= y_rcvd_q + CY'(1);
               end
               if (cycles != '1) begin
                  cycles <= cycles + CW'(1);
               end
               if (x_fin && y_fin) begin
                  state_q <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // x buffer: loads are locked out while sending so the streamed vector stays consistent.
   always_ff @(posedge clk) begin
      if (ld_wr_en && (state_q != StSend)) begin
         x_mem[ld_addr] <= ld_data;
      end
   end

   // Result buffer has no reset: contents survive reset and are replaced only by new y words.
   always_ff @(posedge clk) begin
      if (y_xfer && !reset) begin
         y_mem[y_rcvd_q[AY-1:0]] <= strm.y_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= y_mem[rd_addr];
      end
   end
endmodule

// File: tb/tb_conv_stream_host.sv
// Self-checking bench for conv_stream_host: table of run scenarios with randomized handshakes,
// checked against a schedule model (k-th x word moves on the k-th ready cycle from cycle 2 on,
// k-th y word on the k-th y_valid cycle from cycle 1 on; done follows the later of the two).
module tb_conv_stream_host;
   localparam int T      = 16;
   localparam int SX     = 128;
   localparam int SY     = 121;
   localparam int CW     = 32;
   localparam int BUDGET = 1000;

   logic                clk = 1'b0;
   logic                reset;
   logic                ld_wr_en;
   logic [6:0]          ld_addr;
   logic signed [15:0]  ld_data;
   logic                start;
   logic                busy;
   logic                done;
   logic [CW-1:0]       cycles;
   logic [6:0]          rd_addr;
   logic signed [15:0]  rd_data;

   conv_stream_host_if #(.T(T)) strm ();

   conv_stream_host #(.T(T), .SIZE_X(SX), .SIZE_Y(SY), .CW(CW)) dut (
      .clk      (clk),
      .reset    (reset),
      .ld_wr_en (ld_wr_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .cycles   (cycles),
      .strm     (strm),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic signed [15:0] x_model [SX];
   logic signed [15:0] r_model [SY];
   bit                 r_known [SY];

   typedef struct {
      int rmode;      // 0 ready always, 1 pattern 1,0,0,1, 2 random
      int ymode;      // 0 y_valid always, 1 random
      int n_y;        // y words the accelerator model offers
      bit reload;     // reload x buffer before the run
      bit ramp;       // reload with x[i]=i, else random
      bit inject;     // start pulse + ld_wr_en(5,0x7FFF) during SEND
      int abort_at;   // reset after this many x words (0: run to completion)
      int exp_cycles; // fixed expectation, 0: take it from the schedule model
   } run_t;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load_x(input bit ramp);
      for (int i = 0; i < SX; i++) begin
         x_model[i] = ramp ? 16'(i) : 16'($urandom);
         @(posedge clk); #1;
         ld_wr_en = 1'b1;
         ld_addr  = 7'(i);
         ld_data  = x_model[i];
      end
      @(posedge clk); #1;
      ld_wr_en = 1'b0;
   endtask

   task automatic readback();
      for (int a = 0; a <= SY; a++) begin
         @(posedge clk); #1;
         if (a < SY) rd_addr = 7'(a);
         @(negedge clk);
         if (a > 0 && r_known[a-1]) check($sformatf("result[%0d]", a - 1), rd_data, r_model[a-1]);
      end
   endtask

   task automatic run(input run_t r, input int idx);
      bit                 rdy [BUDGET+1];
      bit                 yv [BUDGET+1];
      int                 xt [SX];
      int                 yt [SY];
      logic signed [15:0] yw [$];
      logic signed [15:0] prev_d;
      bit                 prev_stall;
      bit                 aborting;
      bit                 aborted;
      int                 cnt, last_x, last_y, exp_cyc, xk, yk, done_j, busy_cnt;
      if (r.reload) load_x(r.ramp);
      for (int j = 0; j <= BUDGET; j++) begin
         case (r.rmode)
            0:       rdy[j] = 1'b1;
            1:       rdy[j] = ((j - 1) % 4 == 0) || ((j - 1) % 4 == 3);
            default: rdy[j] = ($urandom_range(0, 3) != 0);
         endcase
         yv[j] = (r.ymode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < r.n_y; k++) yw.push_back(16'($urandom));
      // schedule model
      cnt = 0; last_x = BUDGET;
      for (int j = 2; j <= BUDGET && cnt < SX; j++) if (rdy[j]) begin xt[cnt] = j; cnt++; last_x = j; end
      cnt = 0; last_y = BUDGET;
      for (int j = 1; j <= BUDGET && cnt < SY; j++) if (yv[j]) begin yt[cnt] = j; cnt++; last_y = j; end
      exp_cyc = (r.exp_cycles != 0) ? r.exp_cycles : ((last_x > last_y) ? last_x : last_y);

      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      xk = 0; yk = 0; done_j = 0; busy_cnt = 0; prev_stall = 0; prev_d = '0;
      aborting = 0; aborted = 0;
      for (int j = 1; j <= BUDGET; j++) begin
         start    = 1'b0;
         ld_wr_en = 1'b0;
         if (aborting) begin
            reset = 1'b1;
            strm.y_valid = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check("abort_x_valid", strm.x_valid, 0);
            check("abort_y_ready", strm.y_ready, 0);
            check("abort_busy", busy, 0);
            check("abort_cycles", cycles, 0);
            aborted = 1;
            break;
         end
         strm.x_ready = rdy[j];
         strm.y_valid = yv[j] && (yk < yw.size());
         strm.y_data  = (yk < yw.size()) ? yw[yk] : 16'sd0;
         if (r.inject && j == 10) begin
            start    = 1'b1;
            ld_wr_en = 1'b1;
            ld_addr  = 7'd5;
            ld_data  = 16'sh7fff;
         end
         @(negedge clk);
         if (done) begin
            done_j = j;
            break;
         end
         if (busy) busy_cnt++;
         check("busy", busy, 1);
         check("y_ready", strm.y_ready, (yk < SY) ? 1 : 0);
         if (j == 1) check("x_valid_c1", strm.x_valid, 0);
         if (j == 2) begin
            check("x_valid_c2", strm.x_valid, 1);
            check("x_data_c2", strm.x_data, x_model[0]);
         end
         if (prev_stall) begin
            check("hold_valid", strm.x_valid, 1);
            check("hold_data", strm.x_data, prev_d);
         end
         if (strm.x_valid && strm.x_ready) begin
            if (xk < SX) begin
               check($sformatf("x_word[%0d]", xk), strm.x_data, x_model[xk]);
               check($sformatf("x_time[%0d]", xk), j, xt[xk]);
            end
            xk++;
         end
         if (strm.y_valid && strm.y_ready) begin
            if (yk < SY) begin
               check($sformatf("y_time[%0d]", yk), j, yt[yk]);
               r_model[yk] = yw[yk];
               r_known[yk] = 1'b1;
            end
            yk++;
         end
         prev_stall = strm.x_valid && !strm.x_ready;
         prev_d     = strm.x_data;
         if (r.abort_at != 0 && xk == r.abort_at) aborting = 1;
         @(posedge clk); #1;
      end
      strm.y_valid = 1'b0;
      start    = 1'b0;
      ld_wr_en = 1'b0;
      if (!aborted) begin
         if (done_j == 0) begin
            checks++;
            errors++;
            $display("FAIL run%0d_timeout: no done within %0d cycles", idx, BUDGET);
         end else begin
            check("done_time", done_j - 1, exp_cyc);
            check("cycles", cycles, exp_cyc);
            check("cycles_vs_busy", cycles, busy_cnt);
            check("x_count", xk, SX);
            check("y_count", yk, SY);
            for (int c = 0; c < 3; c++) begin
               @(posedge clk); #1;
               strm.x_ready = 1'b1;
               strm.y_valid = 1'b1;
               @(negedge clk);
               check("done_level", done, 1);
               check("done_x_valid", strm.x_valid, 0);
               check("done_y_ready", strm.y_ready, 0);
               check("done_cycles_hold", cycles, exp_cyc);
            end
            @(posedge clk); #1;
            strm.y_valid = 1'b0;
         end
      end
      readback();
   endtask

   run_t tbl [7];

   initial begin
      tbl[0] = '{0, 0, 121, 1, 1, 0, 0,  129};
      tbl[1] = '{1, 0, 121, 0, 0, 0, 0,  0};
      tbl[2] = '{2, 1, 125, 1, 0, 1, 0,  0};
      tbl[3] = '{0, 0, 121, 0, 0, 0, 0,  129};
      tbl[4] = '{0, 1, 125, 1, 0, 0, 0,  0};
      tbl[5] = '{2, 0, 121, 0, 0, 0, 50, 0};
      tbl[6] = '{0, 0, 121, 1, 1, 0, 0,  129};
      for (int i = 0; i < SY; i++) r_known[i] = 1'b0;

      reset = 1'b1; ld_wr_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; rd_addr = '0;
      strm.x_ready = 1'b0; strm.y_valid = 1'b0; strm.y_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cycles", cycles, 0);
      check("rst_x_valid", strm.x_valid, 0);
      check("rst_x_data", strm.x_data, 0);
      check("rst_y_ready", strm.y_ready, 0);
      check("rst_rd_data", rd_data, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 7; i++) run(tbl[i], i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
